// File: rtl/seg_scan_decoder_if.sv
// ----------------------------------------------------------------------------
// seg_scan_decoder_if
// Bundle between a 4-digit multiplexed 7-segment display driver tap and the
// seg_scan_decoder.
//   sel        [3:0]  digit-select scan lines, raw polarity (sel[0] = rightmost)
//   seg        [6:0]  segment lines, raw polarity (seg[0]=a .. seg[6]=g)
//   data       [15:0] last complete frame, 4 BCD nibbles (data[3:0] = sel[0])
//   data_valid        one-cycle pulse when data updates
//   data_err          OR of digit_err, updated with data
//   digit_err  [3:0]  per-digit invalid-pattern flags for the frame in data
//   scan_stall        high while the display scan has stopped
// master: the side that drives the display lines and consumes the frame.
// slave : the decoder itself.
// ----------------------------------------------------------------------------
interface seg_scan_decoder_if;
  logic [3:0]  sel;
  logic [6:0]  seg;
  logic [15:0] data;
  logic        data_valid;
  logic        data_err;
  logic [3:0]  digit_err;
  logic        scan_stall;

  modport master (
    output sel,
    output seg,
    input  data,
    input  data_valid,
    input  data_err,
    input  digit_err,
    input  scan_stall
  );

  modport slave (
    input  sel,
    input  seg,
    output data,
    output data_valid,
    output data_err,
    output digit_err,
    output scan_stall
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// ----------------------------------------------------------------------------
// seg_scan_decoder
// Snoops a 4-digit multiplexed 7-segment display and reconstructs the number
// shown as four BCD nibbles.
//
// Ports:
//   sys_clk    sole clock, rising edge
//   sys_rst_p  synchronous, active-high reset
//   bus        seg_scan_decoder_if.slave (sel/seg in; data, data_valid,
//              data_err, digit_err, scan_stall out; all outputs registered)
//
// Parameters:
//   STABLE_CYC     identical synchronized samples needed to capture a digit
//                  (2..255)
//   TIMEOUT_CYC    cycles without any capture before scan_stall (20-bit)
//   SEL_ACTIVE_LOW 1 = a low sel bit selects its digit
//   SEG_ACTIVE_LOW 1 = a low seg bit lights its segment
//
// Data path: 2-flop synchronizer -> polarity normalization -> stability
// counter -> capture of one-hot digits into a shadow frame -> frame load into
// the output registers once all four digits have been captured.
// ----------------------------------------------------------------------------
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYC     = 16,
  parameter int unsigned TIMEOUT_CYC    = 1000000,
  parameter bit          SEL_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_p,
  seg_scan_decoder_if.slave bus
);

  localparam logic [7:0]  STB_MAX  = 8'(STABLE_CYC);
  localparam logic [7:0]  STB_PRE  = 8'(STABLE_CYC - 1);
  localparam logic [19:0] TMO_MAX  = 20'(TIMEOUT_CYC);
  localparam logic [19:0] TMO_PRE  = 20'(TIMEOUT_CYC - 1);
  // Synchronizer reset values are the electrically inactive line levels.
  localparam logic [3:0]  SEL_IDLE = SEL_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0]  SEG_IDLE = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  // Normalized gfedcba pattern -> {error, nibble}; anything not 0..9 is F.
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    case (pat)
      7'h3F:   return {1'b0, 4'h0};
      7'h06:   return {1'b0, 4'h1};
      7'h5B:   return {1'b0, 4'h2};
      7'h4F:   return {1'b0, 4'h3};
      7'h66:   return {1'b0, 4'h4};
      7'h6D:   return {1'b0, 4'h5};
      7'h7D:   return {1'b0, 4'h6};
      7'h07:   return {1'b0, 4'h7};
      7'h7F:   return {1'b0, 4'h8};
      7'h6F:   return {1'b0, 4'h9};
      default: return {1'b1, 4'hF};
    endcase
  endfunction

  // True only for exactly one selected digit.
  function automatic logic is_onehot(input logic [3:0] v);
    case (v)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  logic [3:0]  sel_meta;
  logic [3:0]  sel_sync;
  logic [6:0]  seg_meta;
  logic [6:0]  seg_sync;
  logic [3:0]  sel_norm;
  logic [6:0]  seg_norm;
  logic [3:0]  prev_sel;
  logic [6:0]  prev_seg;
  logic [7:0]  stab_cnt;
  logic        sample_same;
  logic        capture;
  logic [4:0]  dec;
  logic [3:0]  mask;
  logic [3:0]  mask_base;
  logic        frame_full;
  logic        load_pend;
  logic        cap_d;
  logic [15:0] shadow_nib;
  logic [3:0]  shadow_err;
  logic [19:0] tmo_cnt;
  logic        tmo_hit;
  logic        stall;
  logic [15:0] frame_data;
  logic        frame_valid;
  logic        frame_err;
  logic [3:0]  frame_digit_err;

  // Two-flop synchronizer for the asynchronous display lines.
  always_ff @(posedge sys_clk) begin
    if (sys_rst_p) begin
      sel_meta <= SEL_IDLE;
      sel_sync <= SEL_IDLE;
      seg_meta <= SEG_IDLE;
      seg_sync <= SEG_IDLE;
    end else begin
      sel_meta <= bus.sel;
      sel_sync <= sel_meta;
      seg_meta <= bus.seg;
      seg_sync <= seg_meta;
    end
  end

  // Polarity normalization, capture qualification and frame-complete detect.
  always_comb begin
    sel_norm    = 4'h0;
    seg_norm    = 7'h00;
    sample_same = 1'b0;
    capture     = 1'b0;
    dec         = 5'h00;
    mask_base   = 4'h0;
    frame_full  = 1'b0;
    tmo_hit     = 1'b0;

    if (SEL_ACTIVE_LOW) begin
      sel_norm = ~sel_sync;
    end else begin
      sel_norm = sel_sync;
    end
    if (SEG_ACTIVE_LOW) begin
      seg_norm = ~seg_sync;
    end else begin
      seg_norm = seg_sync;
    end

    sample_same = ({sel_norm, seg_norm} == {prev_sel, prev_seg});
    // Capture fires on the single cycle the counter steps onto STABLE_CYC,
    // so a saturated counter never re-captures within one stable interval.
    capture     = sample_same && (stab_cnt == STB_PRE) && is_onehot(sel_norm);
    dec         = seg_decode(seg_norm);

    // In the frame-load cycle the mask is about to clear, so a capture made
    // then counts toward the next frame rather than the one being loaded.
    if (load_pend) begin
      mask_base = 4'h0;
    end else begin
      mask_base = mask;
    end
    frame_full = capture && ((mask_base | sel_norm) == 4'hF);

    tmo_hit    = !capture && (tmo_cnt == TMO_PRE);
  end

  // Stability counter over the normalized {sel, seg} sample.
  always_ff @(posedge sys_clk) begin
    if (sys_rst_p) begin
      prev_sel <= 4'h0;
      prev_seg <= 7'h00;
      stab_cnt <= 8'd0;
    end else begin
      prev_sel <= sel_norm;
      prev_seg <= seg_norm;
      if (!sample_same) begin
        stab_cnt <= 8'd0;
      end else if (stab_cnt != STB_MAX) begin
        stab_cnt <= stab_cnt + 8'd1;
      end else begin
        stab_cnt <= stab_cnt;
      end
    end
  end

  // Shadow frame and captured-digit mask.
  always_ff @(posedge sys_clk) begin
    if (sys_rst_p) begin
      shadow_nib <= 16'h0000;
      shadow_err <= 4'h0;
      mask       <= 4'h0;
      load_pend  <= 1'b0;
      cap_d      <= 1'b0;
    end else begin
      load_pend <= frame_full;
      cap_d     <= capture;
      // Latest capture of a digit wins until the frame is loaded.
      for (int i = 0; i < 4; i++) begin
        if (capture && sel_norm[i]) begin
          shadow_nib[i*4 +: 4] <= dec[3:0];
          shadow_err[i]        <= dec[4];
        end else begin
          shadow_nib[i*4 +: 4] <= shadow_nib[i*4 +: 4];
          shadow_err[i]        <= shadow_err[i];
        end
      end
      if (tmo_hit) begin
        mask <= 4'h0;
      end else if (load_pend) begin
        mask <= capture ? sel_norm : 4'h0;
      end else if (capture) begin
        mask <= mask | sel_norm;
      end else begin
        mask <= mask;
      end
    end
  end

  // Scan-activity timeout and stall flag.
  always_ff @(posedge sys_clk) begin
    if (sys_rst_p) begin
      tmo_cnt <= 20'd0;
      stall   <= 1'b0;
    end else begin
      if (capture) begin
        tmo_cnt <= 20'd0;
      end else if (tmo_cnt != TMO_MAX) begin
        tmo_cnt <= tmo_cnt + 20'd1;
      end else begin
        tmo_cnt <= tmo_cnt;
      end
      // Stall drops the cycle after the first capture that follows it.
      if (tmo_hit) begin
        stall <= 1'b1;
      end else if (cap_d) begin
        stall <= 1'b0;
      end else begin
        stall <= stall;
      end
    end
  end

  // Output frame registers, loaded one cycle after the frame completes.
  always_ff @(posedge sys_clk) begin
    if (sys_rst_p) begin
      frame_data      <= 16'h0000;
      frame_digit_err <= 4'h0;
      frame_err       <= 1'b0;
      frame_valid     <= 1'b0;
    end else begin
      frame_valid <= load_pend;
      if (load_pend) begin
        frame_data      <= shadow_nib;
        frame_digit_err <= shadow_err;
        frame_err       <= |shadow_err;
      end else begin
        frame_data      <= frame_data;
        frame_digit_err <= frame_digit_err;
        frame_err       <= frame_err;
      end
    end
  end

  assign bus.data       = frame_data;
  assign bus.data_valid = frame_valid;
  assign bus.data_err   = frame_err;
  assign bus.digit_err  = frame_digit_err;
  assign bus.scan_stall = stall;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// ----------------------------------------------------------------------------
// tb_seg_scan_decoder
// Drives an active-low multiplexed display scan into seg_scan_decoder. Each
// digit held long enough to be captured is fed to a small frame model; every
// completed frame is queued and compared when data_valid pulses.
// ----------------------------------------------------------------------------
module tb_seg_scan_decoder;
  localparam int STB = 16;
  localparam int TMO = 3000;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  err;
  } frame_t;

  logic sys_clk = 1'b0;
  logic sys_rst_p;

  seg_scan_decoder_if bus ();

  seg_scan_decoder #(
    .STABLE_CYC    (STB),
    .TIMEOUT_CYC   (TMO),
    .SEL_ACTIVE_LOW(1'b1),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_p(sys_rst_p),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_valid  = 0;
  frame_t      exp_q[$];
  frame_t      mon_e;
  logic        prev_valid = 1'b0;
  logic [3:0]  m_mask;
  logic [15:0] m_data;
  logic [3:0]  m_errs;
  logic [15:0] m_last_data;

  // Active-high gfedcba pattern of a decimal digit.
  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic model_reset();
    m_mask = 4'h0;
    m_data = 16'h0000;
    m_errs = 4'h0;
  endtask

  task automatic model_capture(input int idx, input logic [3:0] nib, input logic e);
    frame_t f;
    m_data[idx*4 +: 4] = nib;
    m_errs[idx]        = e;
    m_mask[idx]        = 1'b1;
    if (m_mask == 4'hF) begin
      f.data = m_data;
      f.err  = m_errs;
      exp_q.push_back(f);
      m_last_data = m_data;
      m_mask      = 4'h0;
    end
  endtask

  task automatic idle();
    bus.sel = 4'hF;
    bus.seg = 7'h7F;
  endtask

  // Show digit idx with value val (-1 = blank) for cyc cycles.
  task automatic show(input int idx, input int val, input int cyc);
    logic [3:0] s;
    s      = 4'h0;
    s[idx] = 1'b1;
    bus.sel = ~s;
    bus.seg = (val < 0) ? 7'h7F : ~seg_of(val);
    if (cyc >= STB + 2) model_capture(idx, (val < 0) ? 4'hF : 4'(val), (val < 0));
    tick(cyc);
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drained: %0d expected frames never reported, required 0", name, exp_q.size());
    end
  endtask

  // Scoreboard: every data_valid pops and checks one expected frame.
  always @(negedge sys_clk) begin
    if (bus.data_valid === 1'b1) begin
      n_valid++;
      n_checks++;
      if (prev_valid) begin
        n_fail++;
        $display("FAIL valid_width: data_valid high two cycles in a row, required one-cycle pulse");
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: data_valid=1 data=%h, required no frame", bus.data);
      end else begin
        mon_e = exp_q.pop_front();
        n_checks += 3;
        if (bus.data !== mon_e.data) begin
          n_fail++;
          $display("FAIL frame_data: got %h, required %h", bus.data, mon_e.data);
        end
        if (bus.digit_err !== mon_e.err) begin
          n_fail++;
          $display("FAIL frame_digit_err: got %b, required %b", bus.digit_err, mon_e.err);
        end
        if (bus.data_err !== (|mon_e.err)) begin
          n_fail++;
          $display("FAIL frame_data_err: got %b, required %b", bus.data_err, |mon_e.err);
        end
      end
    end
    prev_valid = (bus.data_valid === 1'b1);
  end

  task automatic test_reset();
    sys_rst_p = 1'b1;
    idle();
    model_reset();
    tick(4);
    n_checks += 5;
    if (bus.data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h, required 0000", bus.data); end
    if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", bus.data_valid); end
    if (bus.data_err !== 1'b0) begin n_fail++; $display("FAIL reset_data_err: got %b, required 0", bus.data_err); end
    if (bus.digit_err !== 4'h0) begin n_fail++; $display("FAIL reset_digit_err: got %b, required 0000", bus.digit_err); end
    if (bus.scan_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b, required 0", bus.scan_stall); end
    sys_rst_p = 1'b0;
    tick(30);
  endtask

  task automatic test_scan_1234();
    int v0;
    v0 = n_valid;
    for (int r = 0; r < 2; r++) begin
      show(0, 4, 1000);
      show(1, 3, 1000);
      show(2, 2, 1000);
      show(3, 1, 1000);
    end
    idle();
    tick(30);
    n_checks += 4;
    if (n_valid - v0 != 2) begin n_fail++; $display("FAIL scan_pulses: got %0d, required 2", n_valid - v0); end
    if (bus.data !== 16'h1234) begin n_fail++; $display("FAIL scan_data: got %h, required 1234", bus.data); end
    if (bus.data_err !== 1'b0) begin n_fail++; $display("FAIL scan_data_err: got %b, required 0", bus.data_err); end
    if (bus.digit_err !== 4'h0) begin n_fail++; $display("FAIL scan_digit_err: got %b, required 0000", bus.digit_err); end
    check_drained("scan");
  endtask

  task automatic test_short_digit();
    int v0;
    v0 = n_valid;
    show(0, 8, 200);
    show(1, 7, 10);
    show(2, 6, 200);
    show(3, 5, 200);
    n_checks++;
    if (n_valid != v0) begin n_fail++; $display("FAIL short_no_valid: got %0d pulses, required 0", n_valid - v0); end
    show(1, 7, 200);
    idle();
    tick(30);
    n_checks++;
    if (n_valid - v0 != 1) begin n_fail++; $display("FAIL short_late_valid: got %0d pulses, required 1", n_valid - v0); end
    check_drained("short");
  endtask

  task automatic test_blank();
    show(0, 1, 200);
    show(1, 2, 200);
    show(2, -1, 200);
    show(3, 4, 200);
    idle();
    tick(30);
    n_checks += 3;
    if (bus.data[11:8] !== 4'hF) begin n_fail++; $display("FAIL blank_nibble: got %h, required F", bus.data[11:8]); end
    if (bus.digit_err !== 4'b0100) begin n_fail++; $display("FAIL blank_digit_err: got %b, required 0100", bus.digit_err); end
    if (bus.data_err !== 1'b1) begin n_fail++; $display("FAIL blank_data_err: got %b, required 1", bus.data_err); end
    check_drained("blank");
  endtask

  task automatic test_multihot();
    int v0;
    show(0, 3, 200);
    v0 = n_valid;
    bus.sel = ~4'b0011;
    bus.seg = ~seg_of(8);
    tick(100);
    n_checks++;
    if (n_valid != v0) begin n_fail++; $display("FAIL multihot_no_valid: got %0d pulses, required 0", n_valid - v0); end
    show(1, 1, 200);
    show(2, 2, 200);
    show(3, 3, 200);
    idle();
    tick(30);
    n_checks++;
    if (n_valid - v0 != 1) begin n_fail++; $display("FAIL multihot_frames: got %0d pulses, required 1", n_valid - v0); end
    check_drained("multihot");
  endtask

  task automatic test_recapture();
    show(0, 1, 200);
    show(1, 2, 200);
    show(0, 3, 200);
    show(2, 4, 200);
    show(3, 5, 200);
    idle();
    tick(30);
    n_checks++;
    if (bus.data !== 16'h5423) begin n_fail++; $display("FAIL recapture_data: got %h, required 5423", bus.data); end
    check_drained("recapture");
  endtask

  task automatic test_stall();
    show(0, 9, 200);
    show(1, 9, 200);
    idle();
    tick(1000);
    n_checks++;
    if (bus.scan_stall !== 1'b0) begin n_fail++; $display("FAIL stall_early: got %b, required 0", bus.scan_stall); end
    tick(2200);
    model_reset();
    n_checks += 2;
    if (bus.scan_stall !== 1'b1) begin n_fail++; $display("FAIL stall_set: got %b, required 1", bus.scan_stall); end
    if (bus.data !== m_last_data) begin n_fail++; $display("FAIL stall_data_hold: got %h, required %h", bus.data, m_last_data); end
    // Resume: capture lands 19 edges after the change, stall drops one later.
    bus.sel = ~4'b0100;
    bus.seg = ~seg_of(1);
    model_capture(2, 4'h1, 1'b0);
    tick(18);
    n_checks++;
    if (bus.scan_stall !== 1'b1) begin n_fail++; $display("FAIL stall_before_capture: got %b, required 1", bus.scan_stall); end
    tick(3);
    n_checks++;
    if (bus.scan_stall !== 1'b0) begin n_fail++; $display("FAIL stall_clear: got %b, required 0", bus.scan_stall); end
    tick(179);
    show(3, 0, 200);
    show(0, 2, 200);
    show(1, 3, 200);
    idle();
    tick(30);
    n_checks++;
    if (bus.data !== 16'h0132) begin n_fail++; $display("FAIL stall_resume_data: got %h, required 0132", bus.data); end
    check_drained("stall");
  endtask

  task automatic test_reset_midframe();
    int v0;
    show(0, 5, 200);
    show(1, 5, 200);
    sys_rst_p = 1'b1;
    idle();
    model_reset();
    tick(3);
    n_checks += 3;
    if (bus.data !== 16'h0000) begin n_fail++; $display("FAIL midrst_data: got %h, required 0000", bus.data); end
    if (bus.digit_err !== 4'h0) begin n_fail++; $display("FAIL midrst_digit_err: got %b, required 0000", bus.digit_err); end
    if (bus.scan_stall !== 1'b0) begin n_fail++; $display("FAIL midrst_stall: got %b, required 0", bus.scan_stall); end
    sys_rst_p = 1'b0;
    v0 = n_valid;
    show(2, 9, 200);
    show(3, 0, 200);
    n_checks++;
    if (n_valid != v0) begin n_fail++; $display("FAIL midrst_early_valid: got %0d pulses, required 0", n_valid - v0); end
    show(0, 7, 200);
    show(1, 8, 200);
    idle();
    tick(30);
    n_checks += 2;
    if (n_valid - v0 != 1) begin n_fail++; $display("FAIL midrst_frames: got %0d pulses, required 1", n_valid - v0); end
    if (bus.data !== 16'h0987) begin n_fail++; $display("FAIL midrst_data_final: got %h, required 0987", bus.data); end
    check_drained("midrst");
  endtask

  initial begin
    m_last_data = 16'h0000;
    test_reset();
    test_scan_1234();
    test_short_digit();
    test_blank();
    test_multihot();
    test_recapture();
    test_stall();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYC, default 16: consecutive identical synchronized samples required to capture a digit (range 2..255).
REQ-002 Parameter TIMEOUT_CYC, default 1000000: cycles without any capture before scan_stall asserts (20-bit counter).
REQ-003 Parameter SEL_ACTIVE_LOW, default 1: 1 = sel bit low selects a digit.
REQ-004 Parameter SEG_ACTIVE_LOW, default 1: 1 = seg bit low lights a segment.
REQ-005 sys_clk  input  1  sole clock; all logic on the rising edge.
REQ-006 sys_rst_p  input  1  reset, synchronous, active-high.
REQ-007 sel  input  4  digit-select scan from a 4-digit multiplexed display driver; sel[0] is the rightmost digit.
REQ-008 seg  input  7  segment lines; seg[0]=a through seg[6]=g.
REQ-009 data  output  16  last complete frame as 4 BCD nibbles; data[3:0] is the sel[0] digit.
REQ-010 data_valid  output  1  one-cycle pulse when data updates.
REQ-011 data_err  output  1  OR of digit_err, updated with data.
REQ-012 digit_err  output  4  per-digit invalid-pattern flags for the frame in data.
REQ-013 scan_stall  output  1  level; high while scanning has stopped.

Function
REQ-014 The block SHALL pass sel and seg through a 2-stage synchronizer; thereafter both SHALL be normalized to active-high per SEL_ACTIVE_LOW/SEG_ACTIVE_LOW.
REQ-015 Stability counter: SHALL clear to 0 when the normalized {sel,seg} differs from the previous cycle's; otherwise SHALL increment, saturating at STABLE_CYC.
REQ-016 A capture SHALL occur only in the cycle the stability counter becomes STABLE_CYC and normalized sel is exactly one-hot; sel of zero or multi-hot SHALL never capture.
REQ-017 Capture latency SHALL be 2 + STABLE_CYC cycles from an input change; at most one capture per stable interval.
REQ-018 Decode (normalized gfedcba hex): 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9.
REQ-019 Any other pattern, including blank 00, SHALL decode to nibble F and set that digit's shadow error bit.
REQ-020 A capture SHALL write the nibble and error bit into a shadow register for the selected digit and set its bit in a 4-bit captured mask.
REQ-021 Recapture of an already-masked digit before frame completion SHALL overwrite its shadow entry (latest wins); mask unchanged.
REQ-022 When a capture makes the mask 4'hF, the next cycle SHALL load data/digit_err/data_err from the shadow, pulse data_valid for exactly one cycle, and clear the mask.
REQ-023 A capture in the same cycle as the frame load SHALL start the next frame (its mask bit set after clearing).
REQ-024 Timeout counter SHALL clear on every capture, else increment; on reaching TIMEOUT_CYC it SHALL set scan_stall, clear the mask, and hold.
REQ-025 scan_stall SHALL clear in the cycle after the next capture; data, digit_err, data_err SHALL hold their values while stalled.
REQ-026 No state other than data_valid SHALL change on a cycle with no capture, no frame load, and no timeout.

Reset
REQ-027 With sys_rst_p high at a clock edge: data=0, data_valid=0, data_err=0, digit_err=0, scan_stall=0, mask=0, shadow=0, all counters=0, synchronizer flops at inactive levels (all sel/seg bits = 1 when active-low).
REQ-028 Reset mid-frame SHALL discard partial captures; no data_valid until four fresh digits are captured after release.

Verification
REQ-029 Active-low scan of 16'h1234, 1000 cycles per digit, repeated -> data_valid pulses once per four digits with data=16'h1234, data_err=0, digit_err=0.
REQ-030 One digit's sel held only 10 cycles (STABLE_CYC=16) -> no capture of it; no data_valid until it is held >=16 cycles.
REQ-031 Digit 2 shows blank (seg=7'h7F raw) -> data[11:8]=F, digit_err=4'b0100, data_err=1.
REQ-032 Scanning stops, sel all inactive for TIMEOUT_CYC cycles -> scan_stall=1 and data unchanged; scan resumes -> scan_stall=0 one cycle after first capture.
REQ-033 Reset asserted after two captures, then full scan of 16'h0987 -> first data_valid only after four post-reset captures, data=16'h0987.
REQ-034 Multi-hot sel (normalized 4'b0011) stable for 100 cycles -> no capture, mask unchanged.
